// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor_pkg
//  Purpose  : System widths, BTB defaults and 2-bit counter encodings shared
//             by the branch predictor, its interface and its counter helper.
//  Revision : 1.0 - initial release
// ============================================================================
package branch_predictor_pkg;

  localparam int PC_WIDTH    = 32;
  localparam int DATA_WIDTH  = 32;
  localparam int BTB_ENTRIES = 16;

  // 2-bit saturating counter states: strongly/weakly not-taken, weakly/strongly taken
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef logic [PC_WIDTH-1:0] pc_t;

  // Sequential fall-through address, wrapping modulo 2^PC_WIDTH
  function automatic pc_t pc_plus4(input pc_t pc);
    return pc + pc_t'(4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor_if
//  Purpose  : Fetch-side lookup, EX-side resolution and statistics signals
//             between the pipeline (master) and the branch predictor (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface branch_predictor_if;
  import branch_predictor_pkg::*;

  // Fetch lookup
  pc_t         if_pc;
  logic        pred_taken;
  pc_t         pred_target;

  // EX resolution
  logic        ex_branch;
  pc_t         ex_pc;
  logic        ex_taken;
  pc_t         ex_target;
  logic        ex_pred_taken;
  pc_t         ex_pred_target;
  logic        mispredict;
  pc_t         redirect_pc;

  // Statistics
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  modport master (
    output if_pc, ex_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  if_pc, ex_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, mispredict_cnt
  );

endinterface
`default_nettype wire

// File: rtl/branch_predictor_sat_ctr2.sv
`default_nettype none
// ============================================================================
//  Module   : sat_ctr2
//  Purpose  : Next-state function of a 2-bit saturating up/down counter.
//  Revision : 1.0 - initial release
// ============================================================================
module sat_ctr2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] nxt
);

  // Step toward the outcome, holding at either end of the range
  always_comb begin
    nxt = ctr;
    if (up) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor
//  Purpose  : Direct-mapped BTB with 2-bit counters. Predicts the next fetch
//             PC combinationally, trains from EX resolution, and flags
//             mispredictions with the corrected fetch address.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES  = BTB_ENTRIES,
  parameter int IDX_BITS = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  branch_predictor_if.slave  bp
);

  localparam int TAG_W = PC_WIDTH - IDX_BITS - 2;

  // BTB held in flops so lookups can read asynchronously
  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  pc_t              r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  logic [31:0]      r_branch_cnt;
  logic [31:0]      r_mispredict_cnt;

  logic [IDX_BITS-1:0] w_if_idx;
  logic [TAG_W-1:0]    w_if_tag;
  logic                w_if_hit;
  logic                w_pred_taken;

  logic [IDX_BITS-1:0] w_ex_idx;
  logic [TAG_W-1:0]    w_ex_tag;
  logic                w_ex_hit;
  logic [1:0]          w_ctr_nxt;
  logic                w_mispredict;

  assign w_if_idx = bp.if_pc[IDX_BITS+1:2];
  assign w_if_tag = bp.if_pc[PC_WIDTH-1:IDX_BITS+2];
  assign w_ex_idx = bp.ex_pc[IDX_BITS+1:2];
  assign w_ex_tag = bp.ex_pc[PC_WIDTH-1:IDX_BITS+2];

  // Fetch lookup: reads pre-update contents, no bypass from the EX write
  always_comb begin
    w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    w_pred_taken = w_if_hit && r_ctr[w_if_idx][1];
  end

  assign bp.pred_taken  = w_pred_taken;
  assign bp.pred_target = w_pred_taken ? r_target[w_if_idx] : pc_plus4(bp.if_pc);

  // Misprediction: wrong direction, or taken to a different target
  always_comb begin
    w_mispredict = bp.ex_branch &&
                   ((bp.ex_pred_taken != bp.ex_taken) ||
                    (bp.ex_taken && (bp.ex_pred_target != bp.ex_target)));
  end

  assign bp.mispredict  = w_mispredict;
  assign bp.redirect_pc = bp.ex_taken ? bp.ex_target : pc_plus4(bp.ex_pc);

  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  sat_ctr2 u_sat_ctr2 (
    .ctr (r_ctr[w_ex_idx]),
    .up  (bp.ex_taken),
    .nxt (w_ctr_nxt)
  );

  // BTB training; reset clears every entry and drops any pending update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_WNT;
      end
    end else if (bp.ex_branch) begin
      if (w_ex_hit) begin
        r_ctr[w_ex_idx] <= w_ctr_nxt;
        if (bp.ex_taken) r_target[w_ex_idx] <= bp.ex_target;
      end else if (bp.ex_taken) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= bp.ex_target;
        r_ctr[w_ex_idx]    <= CTR_WT;
      end
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (bp.ex_branch && (r_branch_cnt != 32'hFFFF_FFFF))
        r_branch_cnt <= r_branch_cnt + 32'd1;
      if (w_mispredict && (r_mispredict_cnt != 32'hFFFF_FFFF))
        r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
    end
  end

  assign bp.branch_cnt     = r_branch_cnt;
  assign bp.mispredict_cnt = r_mispredict_cnt;

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

IF-stage branch predictor and EX-stage misprediction detector: the predicting end of the branch path whose resolving end is the EX branch unit. Holds a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters. Gives fetch a predicted next PC every cycle. Trains from the resolved branch outcome in EX, and raises a redirect when the prediction carried down the pipe was wrong.

## Interface
Parameters:
- `ENTRIES`, default 16: number of BTB entries; must be a power of 2, minimum 2.
- `IDX_BITS`, default $clog2(ENTRIES): index width; derived, never overridden.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `if_pc`, in, `PC_WIDTH`: current fetch PC.
- `pred_taken`, out, 1: BTB hit and counter[1] set.
- `pred_target`, out, `PC_WIDTH`: predicted next PC.
- `ex_branch`, in, 1: a conditional branch is resolving in EX this cycle.
- `ex_pc`, in, `PC_WIDTH`: PC of the resolving branch.
- `ex_taken`, in, 1: actual outcome from the EX branch unit.
- `ex_target`, in, `PC_WIDTH`: actual taken target (PC + imm).
- `ex_pred_taken`, in, 1: `pred_taken` captured at fetch and piped to EX.
- `ex_pred_target`, in, `PC_WIDTH`: `pred_target` captured at fetch and piped to EX.
- `mispredict`, out, 1: flush IF/ID and redirect fetch.
- `redirect_pc`, out, `PC_WIDTH`: correct next PC when `mispredict` is 1.
- `branch_cnt`, out, 32: resolved branches since reset.
- `mispredict_cnt`, out, 32: mispredictions since reset.

## Operation
- Address split:
  - index = pc[IDX_BITS+1:2]
  - tag = pc[PC_WIDTH-1:IDX_BITS+2]
  - pc[1:0] is ignored.
- Entry contents: valid (1), tag, target (`PC_WIDTH`), ctr (2).
- Lookup is combinational from the registered array:
  - hit = valid && tag match.
  - `pred_taken` = hit && ctr[1].
  - `pred_target` = `pred_taken` ? entry target : `if_pc` + 4 (modulo 2^`PC_WIDTH`).
- Update occurs on a clock edge with `ex_branch`=1, at the index of `ex_pc`:
  - Hit, taken: ctr saturating increment (max 2'b11); target <= `ex_target`.
  - Hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate. valid <= 1, tag/target <= `ex_pc`/`ex_target`, ctr <= 2'b10. Any existing entry at that index is overwritten.
  - Miss, not taken: no change.
- Misprediction detect, combinational and gated by `ex_branch`: `mispredict` = `ex_branch` && ((`ex_pred_taken` != `ex_taken`) || (`ex_taken` && `ex_pred_target` != `ex_target`)).
- `redirect_pc` = `ex_taken` ? `ex_target` : `ex_pc` + 4. It is driven regardless of `mispredict`.
- Counters:
  - `branch_cnt` increments on every clock edge with `ex_branch`=1.
  - `mispredict_cnt` increments when `mispredict`=1.
  - Both saturate at 32'hFFFF_FFFF.

## Timing
- Prediction latency 0: `pred_*` settle combinationally from `if_pc` in the same cycle.
- Detection latency 0: `mispredict` and `redirect_pc` are valid in the same cycle as `ex_branch`.
- Training takes effect at the edge ending the `ex_branch` cycle. It is visible to lookups from the next cycle.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update contents. There is no write-to-read bypass.
- `rst`=1 at an edge (including mid-operation) clears for all entries:
  - valid <= 0, ctr <= 2'b01, tag/target <= 0.
  - `branch_cnt` and `mispredict_cnt` <= 0.
  - Any update presented in that cycle is dropped.
- Outputs during and after reset:
  - `pred_taken`=0.
  - `pred_target`=`if_pc`+4.
  - `mispredict` follows its inputs combinationally (the pipeline gates `ex_branch` during reset).
  - Counters read 0 from the cycle after the reset edge.
- `ex_branch`=0: no state change, and `mispredict`=0 irrespective of the other EX inputs.

## Structure
- `PC_WIDTH` and `DATA_WIDTH` come from SYSTEM_DEF.vh.
- Add to SYSTEM_DEF.vh: `BTB_ENTRIES` (default for `ENTRIES`), and `CTR_SNT`/`CTR_WNT`/`CTR_WT`/`CTR_ST` = 2'b00/01/10/11.
- One sub-module, `sat_ctr2`: a 2-bit saturating up/down next-state function, instantiated in the update path.
- BTB storage lives in the top module as flop arrays. No RAM macro is used, because reads are asynchronous.
- The `ex_pred_*` pipeline registers live in the IF/ID and ID/EX stage registers, not in this block.

## Test plan
- Reset, then `if_pc`=0x100 -> `pred_taken`=0, `pred_target`=0x104; `branch_cnt`=0.
- Resolve `ex_pc`=0x100, `ex_taken`=1, `ex_target`=0x80, `ex_pred_taken`=0 -> `mispredict`=1, `redirect_pc`=0x80. Next cycle `if_pc`=0x100 gives `pred_taken`=1, `pred_target`=0x80. `mispredict_cnt`=1.
- Hysteresis:
  - Three taken resolutions at 0x100 -> ctr=2'b11.
  - One not-taken -> `pred_taken` still 1.
  - Second not-taken -> `pred_taken`=0, `redirect_pc`=0x104.
- Alias: with `ENTRIES`=16, allocate 0x100, then taken at 0x140 with target 0x200 -> lookup 0x100 misses (`pred_target`=0x104); 0x140 predicts 0x200.
- Same-cycle update and lookup of 0x100 on first allocation -> that cycle `pred_taken`=0; following cycle `pred_taken`=1.
- Wrong target: `ex_pred_taken`=1, `ex_pred_target`=0x80, `ex_taken`=1, `ex_target`=0x90 -> `mispredict`=1, `redirect_pc`=0x90. `rst` asserted mid-sequence -> all predictions are not-taken and counters return 0.
